// File: rtl/vout_pkg.sv
// Shared constants and elaboration-time helpers for the output timing generator.
package vout_pkg;

  localparam logic [1:0] PAT_BLACK = 2'd0;
  localparam logic [1:0] PAT_WHITE = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_GRAD  = 2'd3;

  // Bits needed to hold 0..v-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Number of blocks covering n pixels/lines, partial last block included.
  function automatic int unsigned blk_count(input int unsigned n, input int unsigned k);
    return (n + k - 1) / k;
  endfunction

endpackage

// File: rtl/vout_timing_gen_wrap_counter.sv
// Counter 0..MAX with increment and synchronous clear; wrap_o flags the
// increment that takes it from MAX back to 0.
module wrap_counter
  import vout_pkg::*;
#(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] MAX_L = W'(MAX);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == MAX_L) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = inc_i && !clr_i && (cnt_q == MAX_L);

endmodule

// File: rtl/vout_timing_gen.sv
// Raster timing and test-pattern generator for the output port. It also emits
// the block-grid strobes of the input path so the datapath can be loop-tested.
module vout_timing_gen
  import vout_pkg::*;
#(
  parameter int unsigned H_WIDTH  = 1920,
  parameter int unsigned H_START  = 2008,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_TOTAL  = 2200,
  parameter int unsigned V_HEIGHT = 1080,
  parameter int unsigned V_START  = 1084,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_TOTAL  = 1125,
  parameter int unsigned KH       = 30,
  parameter int unsigned KV       = 30,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       en_i,
  input  logic [1:0]                                 pat_sel_i,
  output logic                                       hs_o,
  output logic                                       vs_o,
  output logic                                       de_o,
  output logic [23:0]                                data_o,
  output logic                                       de_fall_o,
  output logic                                       h_save_o,
  output logic                                       v_save_o,
  output logic [clog2(blk_count(H_WIDTH, KH))-1:0]   hblk_o,
  output logic [clog2(blk_count(V_HEIGHT, KV))-1:0]  vblk_o,
  output logic                                       frame_o
);

  localparam int unsigned HBLKS = blk_count(H_WIDTH, KH);
  localparam int unsigned VBLKS = blk_count(V_HEIGHT, KV);
  localparam int unsigned HBW   = clog2(HBLKS);
  localparam int unsigned VBW   = clog2(VBLKS);
  localparam int unsigned HCW   = clog2(H_TOTAL);
  localparam int unsigned VCW   = clog2(V_TOTAL);
  localparam int unsigned KXW   = clog2(KH);
  localparam int unsigned KYW   = clog2(KV);

  localparam logic [KXW-1:0] KX_LAST = KXW'(KH - 1);
  localparam logic [KYW-1:0] KY_LAST = KYW'(KV - 1);

  logic [HCW-1:0] h_cnt;
  logic           h_wrap;
  logic [VCW-1:0] v_cnt;
  logic           v_wrap;
  logic [KXW-1:0] kx;
  logic           kx_wrap;
  logic [KYW-1:0] ky;
  logic           ky_wrap;
  logic [31:0]    h_ext;
  logic [31:0]    v_ext;
  logic           h_in_act;
  logic           v_in_act;

  logic [HBW-1:0] hblk_d, hblk_q;
  logic [VBW-1:0] vblk_d, vblk_q;

  assign h_ext    = 32'(h_cnt);
  assign v_ext    = 32'(v_cnt);
  assign h_in_act = (h_ext < H_WIDTH);
  assign v_in_act = (v_ext < V_HEIGHT);

  wrap_counter #(.MAX(H_TOTAL - 1), .W(HCW)) u_h_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (en_i),
    .clr_i (1'b0),
    .cnt_o (h_cnt),
    .wrap_o(h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL - 1), .W(VCW)) u_v_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (en_i && h_wrap),
    .clr_i (1'b0),
    .cnt_o (v_cnt),
    .wrap_o(v_wrap)
  );

  wrap_counter #(.MAX(KH - 1), .W(KXW)) u_kx (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (en_i && h_in_act),
    .clr_i (en_i && h_wrap),
    .cnt_o (kx),
    .wrap_o(kx_wrap)
  );

  wrap_counter #(.MAX(KV - 1), .W(KYW)) u_ky (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (en_i && h_wrap && v_in_act),
    .clr_i (v_wrap),
    .cnt_o (ky),
    .wrap_o(ky_wrap)
  );

  // Block indices stop at the last (possibly partial) block: a kx/ky wrap on
  // the final active pixel/line must not push them past HBLKS-1/VBLKS-1.
  always_comb begin
    hblk_d = hblk_q;
    vblk_d = vblk_q;
    if (en_i && h_wrap) begin
      hblk_d = '0;
    end else if (kx_wrap && (h_ext < H_WIDTH - 1)) begin
      hblk_d = hblk_q + HBW'(1);
    end
    if (v_wrap) begin
      vblk_d = '0;
    end else if (ky_wrap && (v_ext < V_HEIGHT - 1)) begin
      vblk_d = vblk_q + VBW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hblk_q <= '0;
      vblk_q <= '0;
    end else begin
      hblk_q <= hblk_d;
      vblk_q <= vblk_d;
    end
  end

  logic           active;
  logic           hs_raw;
  logic           vs_raw;
  logic           fall_raw;
  logic           de_d, hs_d, vs_d, fall_d, hsave_d, vsave_d, frame_d;
  logic [23:0]    data_d;
  logic           de_q, hs_q, vs_q, fall_q, hsave_q, vsave_q, frame_q;
  logic [23:0]    data_q;
  logic [HBW-1:0] hblk_out_q;
  logic [VBW-1:0] vblk_out_q;

  always_comb begin
    active   = h_in_act && v_in_act;
    hs_raw   = (h_ext >= H_START) && (h_ext < H_START + H_SYNC);
    vs_raw   = (v_ext >= V_START) && (v_ext < V_START + V_SYNC);
    fall_raw = (h_ext == H_WIDTH) && v_in_act;

    de_d    = 1'b0;
    hs_d    = ~HS_POL;
    vs_d    = ~VS_POL;
    fall_d  = 1'b0;
    hsave_d = 1'b0;
    vsave_d = 1'b0;
    frame_d = 1'b0;
    data_d  = '0;

    if (en_i) begin
      de_d    = active;
      hs_d    = hs_raw ? HS_POL : ~HS_POL;
      vs_d    = vs_raw ? VS_POL : ~VS_POL;
      fall_d  = fall_raw;
      hsave_d = active && ((kx == KX_LAST) || (h_ext == H_WIDTH - 1));
      vsave_d = fall_raw && ((ky == KY_LAST) || (v_ext == V_HEIGHT - 1));
      frame_d = (h_cnt == '0) && (v_cnt == '0);
      if (active) begin
        case (pat_sel_i)
          PAT_BLACK: data_d = '0;
          PAT_WHITE: data_d = '1;
          PAT_CHECK: data_d = {24{hblk_q[0] ^ vblk_q[0]}};
          PAT_GRAD:  data_d = {3{h_ext[7:0]}};
          default:   data_d = '0;
        endcase
      end
    end
  end

  // Output register stage: everything leaves one cycle after counter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_q       <= 1'b0;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      fall_q     <= 1'b0;
      hsave_q    <= 1'b0;
      vsave_q    <= 1'b0;
      frame_q    <= 1'b0;
      data_q     <= '0;
      hblk_out_q <= '0;
      vblk_out_q <= '0;
    end else begin
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      fall_q     <= fall_d;
      hsave_q    <= hsave_d;
      vsave_q    <= vsave_d;
      frame_q    <= frame_d;
      data_q     <= data_d;
      hblk_out_q <= hblk_q;
      vblk_out_q <= vblk_q;
    end
  end

  assign de_o      = de_q;
  assign hs_o      = hs_q;
  assign vs_o      = vs_q;
  assign de_fall_o = fall_q;
  assign h_save_o  = hsave_q;
  assign v_save_o  = vsave_q;
  assign frame_o   = frame_q;
  assign data_o    = data_q;
  assign hblk_o    = hblk_out_q;
  assign vblk_o    = vblk_out_q;

endmodule

// File: tb/tb_vout_timing_gen.sv
// Scoreboard bench for vout_timing_gen on a small 14x7 raster with 3x3 blocks.
module tb_vout_timing_gen;

  localparam int HW  = 8;
  localparam int HST = 10;
  localparam int HSY = 2;
  localparam int HT  = 14;
  localparam int VH  = 4;
  localparam int VST = 5;
  localparam int VSY = 1;
  localparam int VT  = 7;
  localparam int KH  = 3;
  localparam int KV  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pat;
  logic        hs, vs, de, de_fall, h_save, v_save, frame;
  logic [23:0] data;
  logic [1:0]  hblk;
  logic [0:0]  vblk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fall;
    logic        hsave;
    logic        vsave;
    logic        frame;
    logic [1:0]  hblk;
    logic [0:0]  vblk;
    logic [23:0] data;
  } out_t;

  out_t exp_q[$];
  int   frame_t[$];
  int   checks = 0;
  int   failures = 0;
  int   mh = 0;
  int   mv = 0;

  always #5 clk = ~clk;

  vout_timing_gen #(
    .H_WIDTH(HW), .H_START(HST), .H_SYNC(HSY), .H_TOTAL(HT),
    .V_HEIGHT(VH), .V_START(VST), .V_SYNC(VSY), .V_TOTAL(VT),
    .KH(KH), .KV(KV), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pat_sel_i(pat),
    .hs_o(hs), .vs_o(vs), .de_o(de), .data_o(data),
    .de_fall_o(de_fall), .h_save_o(h_save), .v_save_o(v_save),
    .hblk_o(hblk), .vblk_o(vblk), .frame_o(frame)
  );

  // Expected outputs for the raster position (h,v) under the given inputs.
  function automatic out_t model(input int h, input int v, input bit r,
                                 input bit e, input logic [1:0] p);
    out_t o;
    int   hb, vb;
    bit   act, fall;
    logic [7:0] hl;
    o = '0;
    if (r) return o;
    hb = ((h < HW) ? h : HW - 1) / KH;
    vb = ((v < VH) ? v : VH - 1) / KV;
    o.hblk = 2'(hb);
    o.vblk = 1'(vb);
    if (!e) return o;
    act   = (h < HW) && (v < VH);
    fall  = (h == HW) && (v < VH);
    o.de    = act;
    o.hs    = (h >= HST) && (h < HST + HSY);
    o.vs    = (v >= VST) && (v < VST + VSY);
    o.fall  = fall;
    o.hsave = act && ((h % KH == KH - 1) || (h == HW - 1));
    o.vsave = fall && ((v % KV == KV - 1) || (v == VH - 1));
    o.frame = (h == 0) && (v == 0);
    hl = h[7:0];
    if (act) begin
      case (p)
        2'd0: o.data = 24'h000000;
        2'd1: o.data = 24'hFFFFFF;
        2'd2: o.data = ((hb + vb) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        default: o.data = {hl, hl, hl};
      endcase
    end
    return o;
  endfunction

  task automatic step(input bit r, input bit e, input logic [1:0] p);
    out_t x;
    rst = r;
    en  = e;
    pat = p;
    x = model(mh, mv, r, e, p);
    @(posedge clk);
    exp_q.push_back(x);
    if (r) begin
      mh = 0;
      mv = 0;
    end else if (e) begin
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end
    #1;
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, want);
    end
  endtask

  initial begin : monitor
    int   cyc;
    out_t a;
    out_t e;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {hs, vs, de, de_fall, h_save, v_save, frame, hblk, vblk, data};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs cyc=%0d got=%h exp=%h (hs vs de fall hsave vsave frame hblk vblk data)",
                   cyc, a, e);
        end
        if (frame === 1'b1) frame_t.push_back(cyc);
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    en  = 1'b1;
    pat = 2'd2;
    repeat (3) step(1'b1, 1'b1, 2'd2);
    repeat (HT * VT) step(1'b0, 1'b1, 2'd2);
    repeat (HT * VT) step(1'b0, 1'b1, 2'd3);
    repeat (HT * VT) step(1'b0, 1'b1, 2'($urandom_range(0, 3)));
    while (!(mh == 4 && mv == 1)) step(1'b0, 1'b1, 2'd2);
    repeat (20) step(1'b0, 1'b0, 2'd2);
    while (!(mh == 0 && mv == 0)) step(1'b0, 1'b1, 2'd3);
    while (!(mh == 6 && mv == 2)) step(1'b0, 1'b1, 2'd2);
    step(1'b1, 1'b1, 2'd2);
    repeat (2 * HT * VT) step(1'b0, 1'b1, 2'd2);
    repeat (600) step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                      2'($urandom_range(0, 3)));
    @(negedge clk);
    #1;
    if (frame_t.size() >= 5) begin
      chk_int("frame_period_0", frame_t[1] - frame_t[0], HT * VT);
      chk_int("frame_period_1", frame_t[2] - frame_t[1], HT * VT);
      chk_int("frame_period_en_gap", frame_t[4] - frame_t[3], HT * VT + 20);
    end else begin
      checks++;
      failures++;
      $display("FAIL frame_count got=%0d exp>=5", frame_t.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vout_timing_gen.md
Name: vout_timing_gen

Overview:
Transmit-side counterpart of the input cursor. Generates HDMI-style raster timing (hs/vs/de) for the output port from parameters and drives a 24-bit test-pattern pixel stream. Also emits the same block-grid strobes the input path consumes (de_fall, h_save, v_save, block indices). The fantasy datapath and blk_buffer can therefore be exercised and loop-tested without an external source.

Parameters:
H_WIDTH, 1920, active pixels per line
H_START, 2008, h count at which hsync asserts
H_SYNC, 44, hsync width in pixels
H_TOTAL, 2200, pixels per line including blanking
V_HEIGHT, 1080, active lines per frame
V_START, 1084, line at which vsync asserts
V_SYNC, 5, vsync width in lines
V_TOTAL, 1125, lines per frame
KH, 30, block width in pixels
KV, 30, block height in lines
HS_POL, 1, active level of hs_o
VS_POL, 1, active level of vs_o

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  synchronous reset, active-high
en_i  in  1  advance raster; low freezes counters
pat_sel_i  in  2  0 black, 1 white, 2 block checkerboard, 3 horizontal gradient
hs_o  out  1  horizontal sync, polarity HS_POL
vs_o  out  1  vertical sync, polarity VS_POL
de_o  out  1  active video
data_o  out  24  pixel {R,G,B}
de_fall_o  out  1  one-cycle pulse on the first cycle after the last active pixel of a line
h_save_o  out  1  pulse on the last pixel of each horizontal block, including a partial last block
v_save_o  out  1  pulse coincident with de_fall_o on the last line of each block row, including a partial last row
hblk_o  out  clog2(HBLKS)  block column of current pixel
vblk_o  out  clog2(VBLKS)  block row of current line
frame_o  out  1  pulse when counters are at (0,0)

Behaviour:
- HBLKS = ceil(H_WIDTH/KH) and VBLKS = ceil(V_HEIGHT/KV) are derived localparams.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0. On wrap, v_cnt increments, running 0..V_TOTAL-1 and wrapping to 0.
  - kx runs 0..KH-1 and ky runs 0..KV-1. They index the pixel within the current block.
  - kx and hblk reset at h_cnt wrap. ky and vblk reset at v_cnt wrap.
  - kx wraps at KH-1 and increments hblk, but only while h_cnt < H_WIDTH.
  - ky wraps at KV-1 and increments vblk at each line end while v_cnt < V_HEIGHT.
- Raw decode from the counters:
  - active = (h_cnt < H_WIDTH) && (v_cnt < V_HEIGHT)
  - hs raw = H_START <= h_cnt < H_START+H_SYNC
  - vs raw = V_START <= v_cnt < V_START+V_SYNC; changes only on line boundaries
- Latency: every output is registered with exactly 1 cycle from counter state. All outputs are mutually aligned.
- Output drive:
  - de_o = active.
  - hs_o = HS_POL when hs raw else ~HS_POL; vs_o likewise with VS_POL.
  - de_fall_o is high on the cycle after de_o falls.
  - h_save_o fires when active and (kx == KH-1 or h_cnt == H_WIDTH-1).
  - v_save_o = de_fall condition and (ky == KV-1 or v_cnt == V_HEIGHT-1).
- data_o is 0 whenever de_o = 0. Otherwise, per pat_sel_i:
  - 0: 24'h000000
  - 1: 24'hFFFFFF
  - 2: {24{hblk[0]^vblk[0]}}
  - 3: {3{h_cnt[7:0]}}
- pat_sel_i is sampled every cycle; a change takes effect on the next pixel, mid-line allowed.
- en_i low:
  - All counters hold.
  - de_o, de_fall_o, h_save_o, v_save_o and frame_o are forced 0.
  - hs_o/vs_o are driven inactive and data_o to 0.
  - On re-enable, generation resumes from the held position; no frame restart.
- Reset, including mid-frame:
  - All counters go to 0.
  - de_o, the strobes and data_o go to 0; hs_o = ~HS_POL, vs_o = ~VS_POL.
  - The first cycle after rst_i drops evaluates position (0,0), so frame_o=1 and de_o=1 on the following cycle.
- Block behaviour at edges:
  - No block pulse in blanking.
  - Partial edge blocks yield shorter spans: h_save_o still fires at H_WIDTH-1, and hblk_o never exceeds HBLKS-1.

Decomposition:
- Package vout_pkg holds:
  - pattern select constants PAT_BLACK / PAT_WHITE / PAT_CHECK / PAT_GRAD
  - a clog2 function
  - the HBLKS/VBLKS derivation
- One natural sub-module: wrap_counter, a parameterised MAX counter with inc/clear inputs and a wrap output. It is instantiated four times (h, v, kx/hblk, ky/vblk).

Test Plan:
Bench parameters: H_WIDTH=8, H_START=10, H_SYNC=2, H_TOTAL=14, V_HEIGHT=4, V_START=5, V_SYNC=1, V_TOTAL=7, KH=3, KV=3, polarities 1. This gives HBLKS=3 and VBLKS=2.
- Reset, then release: first output cycle frame_o=1, de_o=1. Per active line, de_o is high 8 cycles, then hs_o high 2 cycles starting 10 cycles after de_o rises. Frame period is 98 cycles.
- Block strobes: h_save_o pulses at pixels 2, 5 and 7 of each line. v_save_o pulses only on lines 2 and 3. hblk_o reads 0,0,0,1,1,1,2,2.
- vs_o is high for exactly 14 cycles beginning at line 5 pixel 0 (cycle offset 70 from frame_o). No de_o, h_save_o or v_save_o is asserted in lines 4–6.
- pat_sel_i=2: line 0 data_o pattern is 0,0,0,FFFFFF×3,0,0; line 3 is inverted. pat_sel_i=3: pixel 5 gives 24'h050505. Blanking data_o=0.
- Drop en_i for 20 cycles at line 1 pixel 4: outputs go idle. On resume, the next de_o pixel is pixel 4 of line 1 and the frame period stretches to 118.
- Assert rst_i at line 2 pixel 6 for 1 cycle: next cycle outputs are in reset state, and frame_o follows one cycle later.
